// File: rtl/tick_period_meter_pkg.sv
// Shared defaults and state encoding for the tick period meter.
package tick_period_meter_pkg;

  localparam int          WIDTH_DEF    = 29;
  // 2 s at 50 MHz; gaps longer than this are reported as a stalled source.
  localparam logic [28:0] MAX_RATE_DEF = 29'd100000000;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_t;

endpackage

// File: rtl/tick_period_meter_edge_detect.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of tick.
// A tick already high when reset releases yields a pulse on the first cycle.
module tick_edge_detect (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic tick,
  output logic rise
);

  logic tick_d;

  // Delayed copy of the strobe, cleared by reset so a held-high level reads as an edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) tick_d <= 1'b0;
    else       tick_d <= tick;
  end

  assign rise = tick & ~tick_d;

endmodule

// File: rtl/tick_period_meter.sv
// Measures cycles between rising tick edges, reports them as period-1,
// tracks lock on a stable period and flags a stalled source.
module tick_period_meter
  import tick_period_meter_pkg::*;
#(
  parameter int               WIDTH      = WIDTH_DEF,
  parameter logic [WIDTH-1:0] MAX_RATE   = WIDTH'(MAX_RATE_DEF),
  parameter int               LOCK_COUNT = 4,
  parameter int               TOL        = 0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             tick,
  output logic [WIDTH-1:0] rate_out,
  output logic             rate_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int               MW     = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    LOCK_N = MW'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] TOL_W  = WIDTH'(TOL);

  state_t           state, state_nxt;
  logic             rise;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rate_nxt;
  logic             valid_nxt, to_nxt, locked_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;

  tick_edge_detect u_edge (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (tick),
    .rise     (rise)
  );

  // Cycles since the last edge; holds at MAX_RATE so the timeout compare stays true.
  always_ff @(posedge CLOCK_50) begin
    if (reset)                 cnt <= '0;
    else if (rise)             cnt <= '0;
    else if (cnt != MAX_RATE)  cnt <= cnt + 1'b1;
  end

  // Unsigned distance between the new measurement and the previous one.
  always_comb diff = (cnt > rate_out) ? (cnt - rate_out) : (rate_out - cnt);

  // Next state plus next values of every registered output; edge beats timeout.
  always_comb begin
    state_nxt  = state;
    rate_nxt   = rate_out;
    valid_nxt  = 1'b0;
    to_nxt     = 1'b0;
    match_nxt  = match_cnt;
    locked_nxt = locked;
    case (state)
      WAIT_FIRST: begin
        if (rise) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          rate_nxt  = cnt;
          valid_nxt = 1'b1;
          if (match_cnt == '0 || diff > TOL_W) match_nxt = MW'(1);
          else if (match_cnt != LOCK_N)        match_nxt = match_cnt + 1'b1;
          locked_nxt = (match_nxt == LOCK_N);
        end else if (cnt == MAX_RATE) begin
          to_nxt     = 1'b1;
          locked_nxt = 1'b0;
          match_nxt  = '0;
          state_nxt  = WAIT_FIRST;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= WAIT_FIRST;
    else       state <= state_nxt;
  end

  // Output and lock-tracking registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rate_out   <= '0;
      rate_valid <= 1'b0;
      timeout    <= 1'b0;
      locked     <= 1'b0;
      match_cnt  <= '0;
    end else begin
      rate_out   <= rate_nxt;
      rate_valid <= valid_nxt;
      timeout    <= to_nxt;
      locked     <= locked_nxt;
      match_cnt  <= match_nxt;
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Randomized and directed bench for tick_period_meter with a time-stamp based model.
module tb_tick_period_meter;

  localparam int W    = 29;
  localparam int MAXR = 20;
  localparam int LOCK = 4;
  localparam int TOLV = 0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tick = 1'b0;
  logic [W-1:0] rate_out;
  logic         rate_valid, locked, timeout;

  int errs = 0;
  int checks = 0;

  // model state: edge time stamps and measurement history
  int cyc = 0;
  int last_edge = 0;
  bit armed = 0;
  bit tick_prev = 0;
  int hist[$];
  int m_rate = 0;
  bit m_valid = 0, m_lock = 0, m_to = 0;

  always #5 clk = ~clk;

  tick_period_meter #(
    .WIDTH      (W),
    .MAX_RATE   (29'(MAXR)),
    .LOCK_COUNT (LOCK),
    .TOL        (TOLV)
  ) u_dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .tick       (tick),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // locked means the last LOCK measurements since arming all agree pairwise-adjacent
  function automatic bit hist_locked();
    if (hist.size() < LOCK) return 0;
    for (int i = 1; i < hist.size(); i++)
      if (absd(hist[i], hist[i-1]) > TOLV) return 0;
    return 1;
  endfunction

  task automatic model_clk();
    bit e;
    m_valid = 0;
    m_to    = 0;
    if (reset) begin
      armed = 0; tick_prev = 0; m_rate = 0; m_lock = 0;
      hist.delete();
    end else begin
      e = tick && !tick_prev;
      tick_prev = tick;
      if (armed && e) begin
        m_rate = cyc - last_edge - 1;
        m_valid = 1;
        hist.push_back(m_rate);
        if (hist.size() > LOCK) void'(hist.pop_front());
        m_lock = hist_locked();
        last_edge = cyc;
      end else if (armed && (cyc - last_edge - 1) == MAXR) begin
        m_to = 1; m_lock = 0; armed = 0;
        hist.delete();
      end else if (!armed && e) begin
        armed = 1;
        last_edge = cyc;
      end
    end
    cyc++;
  endtask

  task automatic step(input bit t, input bit r);
    tick  = t;
    reset = r;
    @(posedge clk);
    model_clk();
    #1;
    chk("rate_out",   32'(rate_out), 32'(m_rate));
    chk("rate_valid", 32'(rate_valid), 32'(m_valid));
    chk("locked",     32'(locked), 32'(m_lock));
    chk("timeout",    32'(timeout), 32'(m_to));
    if (rate_valid && timeout) chk("valid_and_timeout", 32'(1), 32'(0));
  endtask

  task automatic period(input int p, input int hi);
    for (int i = 0; i < p; i++) step(i < hi, 1'b0);
  endtask

  initial begin
    int g, hi;
    g = 10;
    repeat (3) step(1'b0, 1'b1);
    repeat (100) step(1'b0, 1'b0);
    chk("idle_rate", 32'(rate_out), 32'(0));

    // steady rate 9, lock on 4th measurement
    repeat (5) period(10, 1);
    chk("rate9", 32'(rate_out), 32'(9));
    chk("lock9", 32'(locked), 32'(1));

    // one 12-cycle gap breaks lock, re-lock after 4 matching measurements
    period(12, 1);
    period(10, 1);
    chk("gap_rate", 32'(rate_out), 32'(11));
    chk("gap_unlock", 32'(locked), 32'(0));
    repeat (5) period(10, 1);
    chk("relock", 32'(locked), 32'(1));

    // stalled source: timeout, then next edge only re-arms
    step(1'b1, 1'b0);
    repeat (25) step(1'b0, 1'b0);
    chk("to_rate_hold", 32'(rate_out), 32'(9));
    chk("to_unlock", 32'(locked), 32'(0));

    // edges exactly MAX_RATE+1 apart: edge wins over timeout
    repeat (3) period(21, 1);
    chk("max_rate", 32'(rate_out), 32'(20));

    // level is ignored, only rising edges count
    repeat (4) period(10, 5);
    chk("level_rate", 32'(rate_out), 32'(9));

    // reset mid-period clears everything
    repeat (4) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("rst_rate", 32'(rate_out), 32'(0));
    chk("rst_lock", 32'(locked), 32'(0));

    // minimum rate 1 with alternating tick, tick held high across reset release
    repeat (6) period(2, 1);
    chk("rate1", 32'(rate_out), 32'(1));

    // randomized gaps, widths and occasional resets
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) g = $urandom_range(2, 24);
      hi = $urandom_range(1, g - 1);
      if ($urandom_range(0, 40) == 0) begin
        step(1'($urandom_range(0, 1)), 1'b1);
        step(1'($urandom_range(0, 1)), 1'b1);
      end
      period(g, hi);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
Receiving end of the tick-strobe interface. It measures the number of clock cycles between rising edges of an incoming tick strobe and reports the period in the same "rate" encoding the divider consumes: period in cycles minus 1. A divider programmed with rate R therefore reads back as R. Used to check and lock onto game-update and frame ticks, and to flag a stalled tick source.

Parameters:
WIDTH, 29, width of the rate counter and output.
MAX_RATE, 29'd100000000, largest measurable rate; longer gaps are a timeout.
LOCK_COUNT, 4, consecutive matching measurements needed to assert locked (>=2).
TOL, 0, allowed absolute difference between consecutive measurements that still counts as a match.

Ports:
CLOCK_50  input  1  system clock.
reset  input  1  synchronous, active-high reset.
tick  input  1  strobe under measurement; any width; only rising edges count.
rate_out  output  WIDTH  last measured rate (cycles between edges minus 1).
rate_valid  output  1  one-cycle pulse when rate_out updates.
locked  output  1  high after LOCK_COUNT consecutive matching measurements.
timeout  output  1  one-cycle pulse when no edge is seen within MAX_RATE+1 cycles.

Behaviour:
- Reset (sampled on posedge CLOCK_50 while reset=1):
  - rate_out=0, rate_valid=0, locked=0, timeout=0.
  - tick_d=0, cnt=0, match_cnt=0, state=WAIT_FIRST.
- Edge detect: edge = tick & ~tick_d; tick_d is registered every cycle.
  - A tick held high across reset release counts as an edge on the first post-reset cycle.
- Counter cnt: on edge, cnt<=0; otherwise cnt<=cnt+1, saturating at MAX_RATE.
- Edge timing: if edges occur in cycles t0 and t1, then cnt equals (t1-t0)-1 in cycle t1.
- FSM states:
  - WAIT_FIRST: ignore cnt; on edge -> MEASURE. No rate_valid is issued.
  - MEASURE, edge: rate_out<=cnt and rate_valid<=1, visible the cycle after the edge (latency 1). Stay in MEASURE.
  - MEASURE, no edge, cnt==MAX_RATE: timeout<=1 (one cycle), locked<=0, match_cnt<=0 -> WAIT_FIRST. rate_out holds its value.
  - Edge in the same cycle as cnt==MAX_RATE: the edge wins. Valid measurement of MAX_RATE, no timeout.
- Lock logic, evaluated on each valid measurement m (prev = current rate_out):
  - If match_cnt==0, or |m-prev|>TOL: match_cnt<=1.
  - Otherwise: match_cnt<=min(match_cnt+1, LOCK_COUNT).
  - locked = (match_cnt==LOCK_COUNT) as a registered output; it updates in the same cycle as rate_valid.
  - A mismatch drops locked the cycle after the mismatching edge.
- Difference |m-prev|: unsigned compare and subtract the larger minus the smaller. No wrap-around.
- Back-to-back edges need tick to fall between them, so the minimum measurable rate is 1 (alternating 1/0 tick).
- Reset mid-measurement discards the partial count. The next edge only re-arms (WAIT_FIRST).
- rate_valid and timeout are never high in the same cycle.

Decomposition:
- Shared package holds:
  - WIDTH default.
  - State encoding: WAIT_FIRST=1'b0, MEASURE=1'b1.
  - MAX_RATE default for 50 MHz (2 s).
- One natural sub-module: tick_edge_detect. It takes CLOCK_50, reset and tick, and outputs a single-cycle edge pulse. It is reusable for button inputs.
- Counter, FSM and lock logic stay in the top module.

Test Plan:
- Reset release, tick=0 for 100 cycles -> all outputs 0; no rate_valid and no timeout, because the block is still in WAIT_FIRST.
- Tick driven by a divider with rate=9 (1-cycle pulse every 10 cycles) -> first rate_valid one cycle after the 2nd edge with rate_out=9. locked rises with the 4th rate_valid.
- Steady rate 9 while locked, then one gap of 12 cycles -> rate_out=11, locked drops. Three more periods of 10 -> locked is still 0 after 2 matches and reasserts on the 4th matching measurement (TOL=0).
- MAX_RATE=20: one edge, then tick stuck at 0 -> timeout pulse exactly when cnt==20 (21 cycles after the edge). locked=0, rate_out unchanged, and the next edge produces no rate_valid.
- MAX_RATE=20: edges 21 cycles apart -> rate_out=20, rate_valid=1, timeout stays 0 (edge wins).
- Tick held high for 5 cycles per 10-cycle period -> rate_out=9 (level is ignored). Asserting reset mid-period clears all outputs the next cycle.
